// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches from sync-read imem, buffers instructions for decode
module fetch_sequencer #(
    parameter int BIN_DIG = 32,
    parameter int MEM_SIZE = 256,
    parameter int FIFO_DEPTH = 4,
    parameter logic [BIN_DIG-1:0] RESET_PC = '0,
    localparam int AW = $clog2(MEM_SIZE)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_en,
    output logic [AW-1:0]      imem_addr,
    input  logic [BIN_DIG-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [BIN_DIG-1:0] redirect_pc,
    input  logic               halt,
    output logic               inst_valid,
    output logic [BIN_DIG-1:0] inst,
    output logic [BIN_DIG-1:0] inst_pc,
    input  logic               inst_ready,
    output logic               halted
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
    state_t state, state_next;
    logic [BIN_DIG-1:0] pc, req_pc;
    logic resp_pending;
    logic [BIN_DIG-1:0] buf_inst [FIFO_DEPTH];
    logic [BIN_DIG-1:0] buf_pc [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic flush, issue, push, pop;
    assign flush = redirect_valid && state != BOOT;
    assign issue = state == RUN && !halt && !redirect_valid &&
                   (count + (PW+1)'(resp_pending)) < (PW+1)'(FIFO_DEPTH);
    assign push = resp_pending && !flush;
    assign pop = inst_valid && inst_ready;
    assign imem_en = issue;
    assign imem_addr = pc[AW+1:2];
    assign inst_valid = count != '0;
    assign inst = buf_inst[rd_ptr];
    assign inst_pc = buf_pc[rd_ptr];
    assign halted = state == HALTED;
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else state <= state_next;
    end
    // next-state: boot lasts one cycle, halt waits for the outstanding response to land
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (halt && !resp_pending) state_next = HALTED;
            HALTED:  if (!halt) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end
    // PC and request tracking; a redirect drops any in-flight response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            req_pc <= '0;
            resp_pending <= 1'b0;
        end else begin
            pc <= flush ? redirect_pc & ~BIN_DIG'(3) : issue ? pc + BIN_DIG'(4) : pc;
            req_pc <= issue ? pc : req_pc;
            resp_pending <= issue;
        end
    end
    // instruction buffer; pops in the flush cycle still complete before clearing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_inst[i] <= '0;
                buf_pc[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                buf_inst[wr_ptr] <= imem_rdata;
                buf_pc[wr_ptr] <= req_pc;
            end
            wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule
